// File: rtl/memory_mmio_pkg.sv
// Shared encodings, default MMIO addresses and status layout for the
// memory/keyboard MMIO block.
package memory_mmio_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } access_size_e;

    localparam logic [31:0] KBD_DATA_ADDR_DEF = 32'h0000_3FFC;
    localparam logic [31:0] KBD_STAT_ADDR_DEF = 32'h0000_3FF8;

    localparam int unsigned STAT_NOT_EMPTY = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_OVERFLOW  = 2;
    localparam int unsigned STAT_COUNT_LSB = 8;
    localparam int unsigned STAT_COUNT_W   = 8;

    // Byte-enable mask for a little-endian access of the given size and lane
    function automatic logic [3:0] lane_mask(input access_size_e size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: lane_mask = 4'b0001 << lane;
            SIZE_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            default:   lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Keyboard key-code FIFO with sticky overflow; a pop frees a slot for a
// same-cycle push when full.
module kbd_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [DATA_W-1:0]              data_i,
    input  logic                           ovf_clr_i,
    output logic [DATA_W-1:0]              data_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              do_push_c, do_pop_c, full_c, empty_c;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);

    // Set of overflow takes priority over a same-cycle clear
    always_comb begin
        do_pop_c  = pop_i && !empty_c;
        do_push_c = push_i && (!full_c || do_pop_c);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (do_push_c && !do_pop_c) count_d = count_q + CNT_W'(1);
        if (do_pop_c && !do_push_c) count_d = count_q - CNT_W'(1);
        if (ovf_clr_i) ovf_d = 1'b0;
        if (push_i && !do_push_c) ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push_c && !reset) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o     = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign full_o     = full_c;
    assign empty_o    = empty_c;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/memory_kbd_mmio.sv
// Word-organised RAM with byte/half/word access, registered processor and
// display read ports, and a memory-mapped keyboard FIFO.
module memory_kbd_mmio
    import memory_mmio_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 4096,
    parameter int unsigned KBD_FIFO_DEPTH = 8,
    parameter logic [31:0] KBD_DATA_ADDR  = KBD_DATA_ADDR_DEF,
    parameter logic [31:0] KBD_STAT_ADDR  = KBD_STAT_ADDR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        isWrite,
    input  logic        readEnable,
    input  logic [1:0]  accessSize,
    input  logic [31:0] writeData,
    output logic [31:0] RD,
    output logic        misaligned,
    input  logic [31:0] displayAddr,
    output logic [31:0] displayData,
    input  logic [7:0]  key_reg,
    input  logic        sample
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(KBD_FIFO_DEPTH + 1);

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      rd_q, rd_d, disp_q, disp_d, status_c, mem_word_c, wdata_c;
    logic             mis_q, mis_d, sample_q;
    access_size_e     size_c;
    logic [3:0]       wmask_c;
    logic [AW-1:0]    widx_c, disp_idx_c;
    logic             misalign_c, in_range_c, disp_in_range_c, is_data_c, is_stat_c;
    logic             store_c, load_c, push_c, pop_c, ovf_clr_c;
    logic [7:0]       fifo_data;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty, fifo_ovf;
    logic             unused_disp_lane_c;

    assign size_c          = access_size_e'(accessSize);
    assign widx_c          = address[AW+1:2];
    assign disp_idx_c      = displayAddr[AW+1:2];
    assign in_range_c      = (address[31:2] < 30'(DEPTH_WORDS));
    assign disp_in_range_c = (displayAddr[31:2] < 30'(DEPTH_WORDS));
    assign is_data_c       = (address == KBD_DATA_ADDR);
    assign is_stat_c       = (address == KBD_STAT_ADDR);
    assign wmask_c         = lane_mask(size_c, address[1:0]);
    assign unused_disp_lane_c = ^displayAddr[1:0];

    always_comb begin
        misalign_c = 1'b0;
        wdata_c    = writeData;
        case (size_c)
            SIZE_BYTE: begin
                misalign_c = 1'b0;
                wdata_c    = {4{writeData[7:0]}};
            end
            SIZE_HALF: begin
                misalign_c = address[0];
                wdata_c    = {2{writeData[15:0]}};
            end
            default:   misalign_c = |address[1:0];
        endcase
    end

    // A store wins over a simultaneous load; MMIO and out-of-range stores vanish
    assign store_c   = isWrite && !misalign_c && in_range_c && !is_data_c && !is_stat_c && !reset;
    assign load_c    = readEnable && !isWrite && !misalign_c;
    assign pop_c     = load_c && is_data_c;
    assign ovf_clr_c = load_c && is_stat_c;
    assign push_c    = sample && !sample_q;

    always_ff @(posedge clock) begin
        if (store_c) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_c[i]) mem[widx_c][8*i +: 8] <= wdata_c[8*i +: 8];
            end
        end
    end

    always_comb begin
        status_c = '0;
        status_c[STAT_NOT_EMPTY] = !fifo_empty;
        status_c[STAT_FULL]      = fifo_full;
        status_c[STAT_OVERFLOW]  = fifo_ovf;
        status_c[STAT_COUNT_LSB +: STAT_COUNT_W] = 8'(fifo_count);
    end

    always_comb begin
        mem_word_c = mem[widx_c];
        rd_d       = rd_q;
        mis_d      = (isWrite || readEnable) && misalign_c;
        disp_d     = disp_in_range_c ? mem[disp_idx_c] : '0;
        if (load_c) begin
            if (is_data_c)       rd_d = fifo_empty ? '0 : {24'b0, fifo_data};
            else if (is_stat_c)  rd_d = status_c;
            else if (!in_range_c) rd_d = '0;
            else begin
                case (size_c)
                    SIZE_BYTE: rd_d = {24'b0, mem_word_c[{address[1:0], 3'b000} +: 8]};
                    SIZE_HALF: rd_d = address[1] ? {16'b0, mem_word_c[31:16]}
                                                 : {16'b0, mem_word_c[15:0]};
                    default:   rd_d = mem_word_c;
                endcase
            end
        end
    end

    // sample_q resets high so a key held through reset is not taken as new
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q     <= '0;
            disp_q   <= '0;
            mis_q    <= 1'b0;
            sample_q <= 1'b1;
        end else begin
            rd_q     <= rd_d;
            disp_q   <= disp_d;
            mis_q    <= mis_d;
            sample_q <= sample;
        end
    end

    kbd_fifo #(
        .DEPTH  (KBD_FIFO_DEPTH),
        .DATA_W (8)
    ) u_kbd_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (push_c),
        .pop_i      (pop_c),
        .data_i     (key_reg),
        .ovf_clr_i  (ovf_clr_c),
        .data_o     (fifo_data),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_ovf)
    );

    assign RD          = rd_q;
    assign misaligned  = mis_q;
    assign displayData = disp_q;

endmodule

// File: tb/tb_memory_kbd_mmio.sv
// Directed self-checking bench for memory_kbd_mmio: RAM lanes, alignment,
// display port and keyboard FIFO behaviour.
module tb_memory_kbd_mmio;

    localparam logic [31:0] KD = 32'h0000_3FFC;
    localparam logic [31:0] KS = 32'h0000_3FF8;

    logic        clock = 1'b0;
    logic        reset, isWrite, readEnable, sample, misaligned;
    logic [31:0] address, writeData, RD, displayAddr, displayData;
    logic [1:0]  accessSize;
    logic [7:0]  key_reg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    memory_kbd_mmio dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .isWrite     (isWrite),
        .readEnable  (readEnable),
        .accessSize  (accessSize),
        .writeData   (writeData),
        .RD          (RD),
        .misaligned  (misaligned),
        .displayAddr (displayAddr),
        .displayData (displayData),
        .key_reg     (key_reg),
        .sample      (sample)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        address = a; accessSize = sz; writeData = d; isWrite = 1'b1; readEnable = 1'b0;
        tick();
        isWrite = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz);
        address = a; accessSize = sz; readEnable = 1'b1; isWrite = 1'b0;
        tick();
        readEnable = 1'b0;
    endtask

    task automatic push_key(input logic [7:0] k);
        key_reg = k; sample = 1'b1;
        tick();
        sample = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; isWrite = 1'b0; readEnable = 1'b0; sample = 1'b1;
        address = '0; accessSize = 2'b10; writeData = '0; displayAddr = '0; key_reg = 8'h00;
        tick(); tick();
        reset = 1'b0;
        n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %h want %h", RD, 32'h0); end
        n_checks++; if (displayData !== 32'h0) begin n_fail++; $display("FAIL reset_disp: got %h want %h", displayData, 32'h0); end
        n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b want 0", misaligned); end
        tick();
        load(KS, 2'b10);
        n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL reset_held_sample_status: got %h want %h", RD, 32'h0); end
        sample = 1'b0;
        tick();
    endtask

    task automatic test_word();
        store(32'd1000, 2'b10, 32'hA5A5_A5A5);
        load(32'd1000, 2'b10);
        n_checks++; if (RD !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL word_load: got %h want %h", RD, 32'hA5A5_A5A5); end
        displayAddr = 32'd1000;
        tick();
        n_checks++; if (displayData !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL word_display: got %h want %h", displayData, 32'hA5A5_A5A5); end
    endtask

    task automatic test_byte_half();
        store(32'd1001, 2'b00, 32'h0000_0096);
        load(32'd1000, 2'b01);
        n_checks++; if (RD !== 32'h0000_96A5) begin n_fail++; $display("FAIL half_lo: got %h want %h", RD, 32'h0000_96A5); end
        load(32'd1001, 2'b00);
        n_checks++; if (RD !== 32'h0000_0096) begin n_fail++; $display("FAIL byte1: got %h want %h", RD, 32'h0000_0096); end
        load(32'd1002, 2'b01);
        n_checks++; if (RD !== 32'h0000_A5A5) begin n_fail++; $display("FAIL half_hi: got %h want %h", RD, 32'h0000_A5A5); end
        load(32'd1001, 2'b01);
        n_checks++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_load_pulse: got %b want 1", misaligned); end
        n_checks++; if (RD !== 32'h0000_A5A5) begin n_fail++; $display("FAIL mis_load_hold: got %h want %h", RD, 32'h0000_A5A5); end
        tick();
        n_checks++; if (misaligned !== 1'b0) begin n_fail++; $display("FAIL mis_pulse_end: got %b want 0", misaligned); end
        store(32'd1002, 2'b10, 32'hFFFF_FFFF);
        n_checks++; if (misaligned !== 1'b1) begin n_fail++; $display("FAIL mis_store_pulse: got %b want 1", misaligned); end
        load(32'd1000, 2'b10);
        n_checks++; if (RD !== 32'hA5A5_96A5) begin n_fail++; $display("FAIL mis_store_nochange: got %h want %h", RD, 32'hA5A5_96A5); end
        store(32'd1002, 2'b01, 32'hFFFF_1234);
        load(32'd1000, 2'b10);
        n_checks++; if (RD !== 32'h1234_96A5) begin n_fail++; $display("FAIL half_store: got %h want %h", RD, 32'h1234_96A5); end
        load(32'd16384, 2'b10);
        n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL oor_load: got %h want %h", RD, 32'h0); end
    endtask

    task automatic test_display_and_both();
        store(32'd1000, 2'b10, 32'hDEAD_BEEF);
        n_checks++; if (displayData !== 32'h1234_96A5) begin n_fail++; $display("FAIL disp_old: got %h want %h", displayData, 32'h1234_96A5); end
        tick();
        n_checks++; if (displayData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL disp_new: got %h want %h", displayData, 32'hDEAD_BEEF); end
        load(32'd1000, 2'b10);
        address = 32'd1004; accessSize = 2'b10; writeData = 32'h1122_3344; isWrite = 1'b1; readEnable = 1'b1;
        tick();
        isWrite = 1'b0; readEnable = 1'b0;
        n_checks++; if (RD !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL both_no_load: got %h want %h", RD, 32'hDEAD_BEEF); end
        load(32'd1004, 2'b10);
        n_checks++; if (RD !== 32'h1122_3344) begin n_fail++; $display("FAIL both_store: got %h want %h", RD, 32'h1122_3344); end
    endtask

    task automatic test_kbd_basic();
        push_key(8'h50); push_key(8'h51); push_key(8'h52);
        load(KS, 2'b10);
        n_checks++; if (RD !== 32'h0000_0301) begin n_fail++; $display("FAIL kbd_status3: got %h want %h", RD, 32'h0000_0301); end
        for (int i = 0; i < 3; i++) begin
            load(KD, 2'b00);
            n_checks++; if (RD !== 32'(8'h50 + i)) begin n_fail++; $display("FAIL kbd_pop%0d: got %h want %h", i, RD, 32'(8'h50 + i)); end
        end
        load(KD, 2'b10);
        n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL kbd_empty_pop: got %h want %h", RD, 32'h0); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 9; i++) push_key(8'(8'h60 + i));
        load(KS, 2'b10);
        n_checks++; if (RD !== 32'h0000_0807) begin n_fail++; $display("FAIL ovf_status: got %h want %h", RD, 32'h0000_0807); end
        load(KS, 2'b10);
        n_checks++; if (RD !== 32'h0000_0803) begin n_fail++; $display("FAIL ovf_cleared: got %h want %h", RD, 32'h0000_0803); end
        for (int i = 0; i < 8; i++) begin
            load(KD, 2'b10);
            n_checks++; if (RD !== 32'(8'h60 + i)) begin n_fail++; $display("FAIL ovf_pop%0d: got %h want %h", i, RD, 32'(8'h60 + i)); end
        end
        load(KS, 2'b10);
        n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL ovf_drained: got %h want %h", RD, 32'h0); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) push_key(8'(8'h70 + i));
        key_reg = 8'h54; sample = 1'b1;
        address = KD; accessSize = 2'b10; readEnable = 1'b1; isWrite = 1'b0;
        tick();
        readEnable = 1'b0; sample = 1'b0;
        n_checks++; if (RD !== 32'h0000_0070) begin n_fail++; $display("FAIL full_pushpop_rd: got %h want %h", RD, 32'h0000_0070); end
        tick();
        load(KS, 2'b10);
        n_checks++; if (RD !== 32'h0000_0803) begin n_fail++; $display("FAIL full_pushpop_status: got %h want %h", RD, 32'h0000_0803); end
        for (int i = 1; i < 9; i++) begin
            logic [31:0] exp_key;
            exp_key = (i == 8) ? 32'h54 : 32'(8'h70 + i);
            load(KD, 2'b10);
            n_checks++; if (RD !== exp_key) begin n_fail++; $display("FAIL full_pushpop_pop%0d: got %h want %h", i, RD, exp_key); end
        end
    endtask

    task automatic test_reset_mid();
        push_key(8'h80); push_key(8'h81); push_key(8'h82);
        key_reg = 8'h99; sample = 1'b1; reset = 1'b1;
        address = 32'd1000; accessSize = 2'b10; writeData = 32'h0; isWrite = 1'b1;
        tick();
        reset = 1'b0; isWrite = 1'b0;
        tick();
        load(KS, 2'b10);
        n_checks++; if (RD !== 32'h0) begin n_fail++; $display("FAIL rst_mid_status: got %h want %h", RD, 32'h0); end
        load(32'd1000, 2'b10);
        n_checks++; if (RD !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rst_mid_store: got %h want %h", RD, 32'hDEAD_BEEF); end
        sample = 1'b0;
        tick();
        push_key(8'hAB);
        load(KS, 2'b10);
        n_checks++; if (RD !== 32'h0000_0101) begin n_fail++; $display("FAIL rst_mid_repush: got %h want %h", RD, 32'h0000_0101); end
        load(KD, 2'b10);
        n_checks++; if (RD !== 32'h0000_00AB) begin n_fail++; $display("FAIL rst_mid_key: got %h want %h", RD, 32'h0000_00AB); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_half();
        test_display_and_both();
        test_kbd_basic();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_kbd_mmio.md
# memory_kbd_mmio

Parametrised successor to the processor's unified memory: a word-organised RAM with byte/halfword/word access, a registered read port for the multicycle datapath, a second registered read port for the display, and a memory-mapped keyboard FIFO. Key codes from the keyboard front end are captured on each rising edge of `sample` and popped by processor loads from a data address. The block sits between the multicycle control/datapath and the display/keyboard peripherals.

## Interface
- `DEPTH_WORDS`, 4096: RAM size in 32-bit words; byte addresses `0 .. 4*DEPTH_WORDS-1`.
- `KBD_FIFO_DEPTH`, 8: keyboard FIFO entries; power of two, ≥2.
- `KBD_DATA_ADDR`, 32'h0000_3FFC: load pops one key code.
- `KBD_STAT_ADDR`, 32'h0000_3FF8: load returns keyboard status.

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `address`  in  32  byte address of the processor access.
- `isWrite`  in  1  store strobe.
- `readEnable`  in  1  load strobe.
- `accessSize`  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- `writeData`  in  32  store data, right-aligned for byte/halfword.
- `RD`  out  32  registered load data, zero-extended.
- `misaligned`  out  1  one-cycle pulse on a rejected misaligned access.
- `displayAddr`  in  32  display byte address; bits [1:0] ignored.
- `displayData`  out  32  registered word at `displayAddr`.
- `key_reg`  in  8  key code from keyboard front end (already in `clock` domain).
- `sample`  in  1  key-valid level; rising edge = new key.

## Operation
- Little-endian lanes: byte lane = `address[1:0]`; halfword uses `address[1]`.
- Alignment: halfword needs `address[0]==0`, word needs `address[1:0]==00`. Misaligned store: no RAM change. Misaligned load: `RD` holds. Both pulse `misaligned`.
- Store in range: only selected lanes written. Store to either MMIO address or out of range: ignored, no error.
- Load in range: `RD` = selected byte/halfword zero-extended, or full word. Out of range (non-MMIO): `RD` = 0.
- `isWrite` and `readEnable` both high: store only; no load, no pop.
- Keyboard push: `sample` high while `sample_q` low pushes `key_reg`. Full FIFO: key dropped, sticky `overflow` set.
- Load at `KBD_DATA_ADDR` (any size): non-empty pops, `RD = {24'b0, key}`; empty gives `RD = 0`, no pop.
- Load at `KBD_STAT_ADDR`: `RD` = {16'b0, count[7:0], 5'b0, overflow, full, notEmpty}. This load clears `overflow` (value returned is pre-clear).
- Push and pop in one cycle: non-empty → both happen, count unchanged. Full → pop frees a slot, push accepted, no overflow. Empty → `RD = 0`, push stored.
- Overflow set and status read in one cycle: set wins.
- Pointers wrap modulo `KBD_FIFO_DEPTH`; count is `$clog2(KBD_FIFO_DEPTH+1)` bits.

## Timing
- `RD`: updated on the edge where `readEnable` is sampled high; valid the next cycle; holds otherwise.
- `displayData`: updated every edge from `displayAddr`; 1-cycle latency. Same-cycle write to that word: old data, new data one cycle later.
- Store: RAM updated on the sampling edge. A load of that address in the next cycle sees new data.
- Key visible to loads the cycle after the `sample` rising edge.
- Reset: `RD`=0, `displayData`=0, `misaligned`=0, FIFO empty, `overflow`=0, `sample_q`=1 (a `sample` held high through reset does not push). RAM contents not reset.
- Reset mid-operation discards queued keys and suppresses any same-cycle store, load, push or pop.

## Structure
- Package `memory_mmio_pkg`:
  - access-size encodings
  - default MMIO addresses
  - status bit positions
  - lane-mask function
- Submodule `kbd_fifo`, parametrised by depth, with push, pop, data, count, full, empty and sticky overflow with clear.
- RAM is an inferred array in the top level.

## Test plan
- Word store 32'hA5A5A5A5 @1000, word load @1000 → `RD`=32'hA5A5A5A5 next cycle. `displayAddr`=1000 → `displayData` same.
- Byte store 8'h96 @1001, then halfword load @1000 → `RD`=32'h0000_96A5. Halfword load @1001 → `misaligned` pulse, `RD` unchanged.
- `sample` edges with `key_reg` 50, 51, 52. Status load → count 3, notEmpty. Three data loads → 50, 51, 52. Fourth data load → 0.
- Push 9 keys (depth 8) → status full=1, overflow=1. Second status read → overflow=0. Pops return the first 8 keys.
- Full FIFO, pop and rising `sample` (key 54) same cycle → count stays 8, no overflow, key 54 last out.
- `reset` with 3 queued keys and `sample` held high → count 0, no push until `sample` falls and rises.
